// File: rtl/mw_add_pkg.sv
// Shared constants, FSM state type and helpers for the multi-word adder.
// Optional subtract support is enabled by defining MW_ADD_SUB_EN.
package mw_add_pkg;

    localparam int WORD_W     = 16;
    localparam int NWORDS_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Slice counter width; at least one bit so NWORDS=2 still counts 0..1.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mw_add64_if.sv
// Operand/result handshake bundle for mw_add64.
// The sub signal exists only when MW_ADD_SUB_EN is defined.
interface mw_add64_if
    import mw_add_pkg::*;
#(
    parameter int NWORDS = NWORDS_DEF
);

    localparam int W = WORD_W * NWORDS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef MW_ADD_SUB_EN
    logic         sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    modport master (
        output in_valid, a, b, cin,
`ifdef MW_ADD_SUB_EN
        output sub,
`endif
        output out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, cin,
`ifdef MW_ADD_SUB_EN
        input  sub,
`endif
        input  out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );

endinterface

// File: rtl/add16.sv
// 16-bit ripple-carry slice adder, reused once per RUN cycle.
module add16
    import mw_add_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              cin,
    output logic [WORD_W-1:0] sum,
    output logic              cout
);

    logic c;

    always_comb begin
        sum = '0;
        c   = cin;
        for (int i = 0; i < WORD_W; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/mw_add64.sv
// Multi-cycle wide adder: one 16-bit slice per cycle through a shared add16.
// Define MW_ADD_SUB_EN to add the sub input (A - B via inverted B, carry-in 1).
module mw_add64
    import mw_add_pkg::*;
#(
    parameter int NWORDS = NWORDS_DEF
) (
    input logic       clk,
    input logic       rst,
    mw_add64_if.slave bus
);

    localparam int W  = WORD_W * NWORDS;
    localparam int CW = cnt_w(NWORDS);
    localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic              carry;
    logic [W-1:0]      a_q;
    logic [W-1:0]      b_q;
    logic [W-1:0]      sum_q;
    logic              cout_q;
    logic              ovf_q;
    logic [WORD_W-1:0] a_sl;
    logic [WORD_W-1:0] b_sl;
    logic [WORD_W-1:0] s_sl;
    logic              c_out;
    logic              c_msb;
    logic              cin_eff;

`ifdef MW_ADD_SUB_EN
    logic sub_q;
    assign cin_eff = bus.sub | bus.cin;
`else
    assign cin_eff = bus.cin;
`endif

    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int k = 0; k < NWORDS; k++) begin
            if (cnt == CW'(k)) begin
                a_sl = a_q[k*WORD_W +: WORD_W];
                b_sl = b_q[k*WORD_W +: WORD_W];
            end
        end
`ifdef MW_ADD_SUB_EN
        if (sub_q)
            b_sl = ~b_sl;
`endif
    end

    add16 u_add16 (
        .a    (a_sl),
        .b    (b_sl),
        .cin  (carry),
        .sum  (s_sl),
        .cout (c_out)
    );

    // Carry into the MSB recovered from the top bit's sum equation.
    assign c_msb = a_sl[WORD_W-1] ^ b_sl[WORD_W-1] ^ s_sl[WORD_W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            carry  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
`ifdef MW_ADD_SUB_EN
            sub_q  <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q   <= bus.a;
                        b_q   <= bus.b;
                        cnt   <= '0;
                        carry <= cin_eff;
`ifdef MW_ADD_SUB_EN
                        sub_q <= bus.sub;
`endif
                        state <= RUN;
                    end
                end
                RUN: begin
                    for (int k = 0; k < NWORDS; k++) begin
                        if (cnt == CW'(k))
                            sum_q[k*WORD_W +: WORD_W] <= s_sl;
                    end
                    carry <= c_out;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        cout_q <= c_out;
                        ovf_q  <= c_msb ^ c_out;
                        cnt    <= '0;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_mw_add64.sv
// Self-checking bench for mw_add64 against a plain-arithmetic reference.
// Subtract scenarios compile in only when MW_ADD_SUB_EN is defined.
module tb_mw_add64;
    import mw_add_pkg::*;

    localparam int NW = 4;
    localparam int W  = WORD_W * NW;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mw_add64_if #(.NWORDS(NW)) bus ();

    mw_add64 #(.NWORDS(NW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < W / 32; i++)
            v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference: whole-width arithmetic, overflow from operand/result signs.
    task automatic ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic ci, input logic s,
                           output logic [W-1:0] r, output logic co,
                           output logic ov);
        logic [W:0]   t;
        logic [W-1:0] be;
        logic         c;
        be = s ? ~b : b;
        c  = s ? 1'b1 : ci;
        t  = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, c};
        r  = t[W-1:0];
        co = t[W];
        ov = (a[W-1] == be[W-1]) && (r[W-1] != a[W-1]);
    endtask

    task automatic drive_in(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic ci, input logic s);
        bus.a   = a;
        bus.b   = b;
        bus.cin = ci;
`ifdef MW_ADD_SUB_EN
        bus.sub = s;
`else
        if (s) $display("note: sub requested without MW_ADD_SUB_EN");
`endif
    endtask

    // Accepts one operand set, scrambles inputs, waits for out_valid.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic s,
                          output logic [W-1:0] r, output logic co,
                          output logic ov, output int lat);
        drive_in(a, b, ci, s);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        drive_in(rnd(), rnd(), 1'($urandom), 1'b0);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            if (lat < 0) begin
                @(posedge clk); #1;
                if (bus.out_valid) lat = i;
            end
        end
        r  = bus.sum;
        co = bus.cout;
        ov = bus.ovf;
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic check_op(input string name, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic ci,
                            input logic s);
        logic [W-1:0] r, er;
        logic co, ov, eco, eov;
        int lat;
        ref_add(a, b, ci, s, er, eco, eov);
        run_op(a, b, ci, s, r, co, ov, lat);
        checks++;
        if (lat !== NW) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, NW);
        end
        checks++;
        if ({r, co, ov} !== {er, eco, eov}) begin
            errors++;
            $display("FAIL %s result: got %h c%b v%b want %h c%b v%b",
                     name, r, co, ov, er, eco, eov);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s in_ready in DONE: got %b want 0",
                     name, bus.in_ready);
        end
        release_out();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.busy, bus.sum, bus.cout,
             bus.ovf} !== {1'b1, 1'b0, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: got rdy%b ov%b bsy%b %h %b %b want 1 0 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.busy, bus.sum,
                     bus.cout, bus.ovf);
        end
    endtask

    task automatic test_vectors();
        check_op("carry16", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
        check_op("ripple", {W{1'b1}}, '0, 1'b1, 1'b0);
        check_op("ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        check_op("negovf", 64'h8000_0000_0000_0000,
                 64'h8000_0000_0000_0000, 1'b0, 1'b0);
        check_op("zero", '0, '0, 1'b0, 1'b0);
`ifdef MW_ADD_SUB_EN
        check_op("sub_borrow", 64'h5, 64'h7, 1'b0, 1'b1);
        check_op("sub_noborrow", 64'h7, 64'h5, 1'b0, 1'b1);
        check_op("sub_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1);
`endif
    endtask

    task automatic test_random();
        logic s;
        for (int i = 0; i < 25; i++) begin
            s = 1'b0;
`ifdef MW_ADD_SUB_EN
            s = 1'($urandom);
`endif
            check_op($sformatf("rand%0d", i), rnd(), rnd(),
                     1'($urandom), s);
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] r, er, a2, b2;
        logic co, ov, eco, eov;
        int lat;
        run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1,
               1'b0, r, co, ov, lat);
        ref_add(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1,
                1'b0, er, eco, eov);
        a2 = rnd();
        b2 = rnd();
        drive_in(a2, b2, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({bus.out_valid, bus.in_ready, bus.sum, bus.cout, bus.ovf}
                !== {1'b1, 1'b0, er, eco, eov}) begin
                errors++;
                $display("FAIL stall%0d: got v%b r%b %h %b %b want 1 0 %h %b %b",
                         i, bus.out_valid, bus.in_ready, bus.sum, bus.cout,
                         bus.ovf, er, eco, eov);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++;
        if ({bus.in_ready, bus.busy} !== 2'b10) begin
            errors++;
            $display("FAIL stall_release: got rdy%b bsy%b want rdy1 bsy0",
                     bus.in_ready, bus.busy);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL stall_accept: got busy %b want 1", bus.busy);
        end
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            if (lat < 0) begin
                @(posedge clk); #1;
                if (bus.out_valid) lat = i;
            end
        end
        ref_add(a2, b2, 1'b0, 1'b0, er, eco, eov);
        checks++;
        if (lat !== NW || {bus.sum, bus.cout, bus.ovf} !== {er, eco, eov}) begin
            errors++;
            $display("FAIL stall_next: got lat%0d %h want lat%0d %h",
                     lat, bus.sum, NW, er);
        end
        release_out();
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        drive_in(64'hFFFF_0000_FFFF_0000, 64'h0001_0001_0001_0001, 1'b1, 1'b0);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.busy, bus.sum, bus.cout,
             bus.ovf} !== {1'b1, 1'b0, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midrun_reset: got rdy%b v%b %h want rdy1 v0 0",
                     bus.in_ready, bus.out_valid, bus.sum);
        end
        seen = 1'b0;
        for (int i = 0; i < NW + 3; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL midrun_no_valid: got out_valid 1 want 0");
        end
        check_op("after_reset", 64'hFFFF_0000_FFFF_0000,
                 64'h0001_0001_0001_0001, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] r, er, a, b;
        logic co, ov, eco, eov;
        int lat;
        for (int i = 0; i < 4; i++) begin
            a = rnd();
            b = rnd();
            ref_add(a, b, 1'b0, 1'b0, er, eco, eov);
            run_op(a, b, 1'b0, 1'b0, r, co, ov, lat);
            checks++;
            if (lat !== NW || {r, co, ov} !== {er, eco, eov}) begin
                errors++;
                $display("FAIL b2b%0d: got lat%0d %h want lat%0d %h",
                         i, lat, r, NW, er);
            end
            drive_in(rnd(), rnd(), 1'b1, 1'b0);
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
            bus.in_valid  = 1'b0;
            checks++;
            if ({bus.in_ready, bus.busy} !== 2'b10) begin
                errors++;
                $display("FAIL b2b_nobypass%0d: got rdy%b bsy%b want 1 0",
                         i, bus.in_ready, bus.busy);
            end
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive_in('0, '0, 1'b0, 1'b0);
        test_reset();
        test_vectors();
        test_random();
        test_stall();
        test_reset_mid_run();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
